// File: rtl/timed_count_buffer.sv
// timed_count_buffer: captures interval count results from dsp_timed_counter
// into a small first-word-fall-through FIFO. Each entry is tagged with a
// threshold-exceeded flag, and entries are presented on a valid/ready port.
// In ACKNOWLEDGE mode the block also returns a one-cycle ack pulse to the
// counter, so that each held result is captured exactly once.
module timed_count_buffer #(
    parameter string             MODE        = "NORMAL",
    parameter int                WIDTH       = 24,
    parameter int                DEPTH_LOG2  = 2,
    parameter logic [WIDTH-1:0]  THRESH_INIT = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  count_in_valid,
    output logic                  count_ack,
    input  logic [WIDTH-1:0]      thresh_in,
    input  logic                  thresh_load,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_over,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam bit                  ACK_MODE   = (MODE == "ACKNOWLEDGE");

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [WIDTH-1:0]        mem_count [DEPTH];
    logic                    mem_over  [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     count;
    logic [WIDTH-1:0]        threshold;

    logic                    full;
    logic                    empty;
    logic                    pop;
    logic                    push_req;
    logic                    push;
    logic                    drop;
    logic                    over_in;

    // Handshake decode. Popping frees a slot in the same cycle, so a push
    // into a full FIFO is still accepted when a pop happens alongside it.
    always_comb begin
        full     = (count == FULL_LEVEL);
        empty    = (count == '0);
        pop      = !empty && dout_ready;
        push_req = ACK_MODE ? (count_in_valid && (state == ST_IDLE)) : count_in_valid;
        push     = push_req && (!full || pop);
        drop     = !ACK_MODE && count_in_valid && full && !pop;
        over_in  = (count_in >= threshold);
    end

    // Storage and pointers; pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_count[i] <= '0;
                mem_over[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_count[wr_ptr] <= count_in;
                mem_over[wr_ptr]  <= over_in;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy counter; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Threshold register; the compare above always sees the pre-load value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            threshold <= THRESH_INIT;
        end else if (thresh_load) begin
            threshold <= thresh_in;
        end
    end

    // Sticky overflow flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    // Acknowledge FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Acknowledge FSM: capture, pulse ack once, then wait for valid to drop.
    always_comb begin
        state_next = state;
        count_ack  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ACK_MODE && push) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                count_ack  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!count_in_valid) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FWFT head; outputs are forced to zero while the FIFO is empty.
    always_comb begin
        dout_valid = !empty;
        level      = count;
        dout       = empty ? '0 : mem_count[rd_ptr];
        dout_over  = empty ? 1'b0 : mem_over[rd_ptr];
    end

endmodule

// File: tb/tb_timed_count_buffer.sv
// tb_timed_count_buffer: checks a NORMAL-mode instance (index 0) and an
// ACKNOWLEDGE-mode instance (index 1) against a queue-based behavioural model,
// plus hand-computed literal expectations taken at key points.
module tb_timed_count_buffer;

    localparam int WIDTH = 24;
    localparam int DEPTH = 4;

    logic              clk;
    logic              rst_n;
    logic [WIDTH-1:0]  count_in       [2];
    logic              count_in_valid [2];
    logic              count_ack      [2];
    logic [WIDTH-1:0]  thresh_in      [2];
    logic              thresh_load    [2];
    logic [WIDTH-1:0]  dout           [2];
    logic              dout_over      [2];
    logic              dout_valid     [2];
    logic              dout_ready     [2];
    logic [2:0]        level          [2];
    logic              overflow       [2];
    logic              overflow_clr   [2];

    int checks = 0;
    int errors = 0;

    timed_count_buffer #(
        .MODE("NORMAL"), .WIDTH(WIDTH), .DEPTH_LOG2(2), .THRESH_INIT(24'd0)
    ) dut_normal (
        .clk(clk), .rst_n(rst_n),
        .count_in(count_in[0]), .count_in_valid(count_in_valid[0]), .count_ack(count_ack[0]),
        .thresh_in(thresh_in[0]), .thresh_load(thresh_load[0]),
        .dout(dout[0]), .dout_over(dout_over[0]), .dout_valid(dout_valid[0]),
        .dout_ready(dout_ready[0]), .level(level[0]),
        .overflow(overflow[0]), .overflow_clr(overflow_clr[0])
    );

    timed_count_buffer #(
        .MODE("ACKNOWLEDGE"), .WIDTH(WIDTH), .DEPTH_LOG2(2), .THRESH_INIT(24'd40)
    ) dut_ack (
        .clk(clk), .rst_n(rst_n),
        .count_in(count_in[1]), .count_in_valid(count_in_valid[1]), .count_ack(count_ack[1]),
        .thresh_in(thresh_in[1]), .thresh_load(thresh_load[1]),
        .dout(dout[1]), .dout_over(dout_over[1]), .dout_valid(dout_valid[1]),
        .dout_ready(dout_ready[1]), .level(level[1]),
        .overflow(overflow[1]), .overflow_clr(overflow_clr[1])
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: an ordered list of {over, count} entries per instance.
    logic [WIDTH:0]    m_q    [2][DEPTH];
    int                m_size [2];
    logic [WIDTH-1:0]  m_thr  [2];
    bit                m_ovf  [2];
    bit                m_ack  [2];
    bit                m_wait [2];

    // Model update on each clock edge, using the inputs held before the edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_size[k] = 0;
                m_thr[k]  = (k == 0) ? 24'd0 : 24'd40;
                m_ovf[k]  = 1'b0;
                m_ack[k]  = 1'b0;
                m_wait[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit             do_pop;
                bit             room;
                bit             take;
                logic [WIDTH:0] entry;
                do_pop = (m_size[k] > 0) && dout_ready[k];
                room   = (m_size[k] < DEPTH) || do_pop;
                entry  = {(count_in[k] >= m_thr[k]), count_in[k]};
                take   = 1'b0;
                if (k == 0) begin
                    take = count_in_valid[k] && room;
                    if (count_in_valid[k] && !room) m_ovf[k] = 1'b1;
                    else if (overflow_clr[k])       m_ovf[k] = 1'b0;
                end else begin
                    if (m_ack[k]) begin
                        m_ack[k]  = 1'b0;
                        m_wait[k] = 1'b1;
                    end else if (m_wait[k]) begin
                        if (!count_in_valid[k]) m_wait[k] = 1'b0;
                    end else if (count_in_valid[k] && room) begin
                        take     = 1'b1;
                        m_ack[k] = 1'b1;
                    end
                end
                if (do_pop) begin
                    for (int i = 0; i < DEPTH - 1; i++) m_q[k][i] = m_q[k][i+1];
                    m_size[k] = m_size[k] - 1;
                end
                if (take) begin
                    m_q[k][m_size[k]] = entry;
                    m_size[k] = m_size[k] + 1;
                end
                if (thresh_load[k]) m_thr[k] = thresh_in[k];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [WIDTH:0] head;
            head = (m_size[k] > 0) ? m_q[k][0] : '0;
            checkOutput($sformatf("m%0d.dout", k),       32'(dout[k]),       32'(head[WIDTH-1:0]));
            checkOutput($sformatf("m%0d.dout_over", k),  32'(dout_over[k]),  32'(head[WIDTH]));
            checkOutput($sformatf("m%0d.dout_valid", k), 32'(dout_valid[k]), 32'(m_size[k] > 0));
            checkOutput($sformatf("m%0d.level", k),      32'(level[k]),      32'(m_size[k]));
            checkOutput($sformatf("m%0d.overflow", k),   32'(overflow[k]),   32'(m_ovf[k]));
            checkOutput($sformatf("m%0d.count_ack", k),  32'(count_ack[k]),  32'(m_ack[k]));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one instance's data-path inputs and advance one clock.
    task automatic applyStimulus(input int k, input logic v, input logic [WIDTH-1:0] c, input logic r);
        count_in_valid[k] = v;
        count_in[k]       = c;
        dout_ready[k]     = r;
        cycle();
    endtask

    // Check the head/level/flags of one instance against literal values.
    task automatic checkHead(input string tag, input int k, input int d, input int o, input int lv);
        checkOutput({tag, ".dout"},      32'(dout[k]),      d);
        checkOutput({tag, ".dout_over"}, 32'(dout_over[k]), o);
        checkOutput({tag, ".level"},     32'(level[k]),     lv);
    endtask

    initial begin
        int exp_d1[4];
        int exp_d2[4];
        int exp_o2[4];
        exp_d1 = '{2, 3, 4, 6};
        exp_d2 = '{31, 32, 33, 99};
        exp_o2 = '{0, 0, 0, 1};

        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            count_in[k] = '0; count_in_valid[k] = 1'b0; thresh_in[k] = '0;
            thresh_load[k] = 1'b0; dout_ready[k] = 1'b0; overflow_clr[k] = 1'b0;
        end
        #2 rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checkHead("reset", k, 0, 0, 0);
            checkOutput("reset.overflow", 32'(overflow[k]), 0);
            checkOutput("reset.count_ack", 32'(count_ack[k]), 0);
        end

        $display("[TB] NORMAL: three pushes with threshold 50");
        thresh_in[0] = 24'd50; thresh_load[0] = 1'b1;
        cycle();
        thresh_load[0] = 1'b0;
        applyStimulus(0, 1, 10, 0);
        applyStimulus(0, 1, 60, 0);
        applyStimulus(0, 1, 5, 0);
        applyStimulus(0, 0, 0, 0);
        checkHead("t1.a", 0, 10, 0, 3);
        applyStimulus(0, 0, 0, 1);
        checkHead("t1.b", 0, 60, 1, 2);
        applyStimulus(0, 0, 0, 1);
        checkHead("t1.c", 0, 5, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkHead("t1.d", 0, 0, 0, 0);

        $display("[TB] NORMAL: overflow on fifth push, then clear");
        for (int v = 1; v <= 5; v++) applyStimulus(0, 1, 24'(v), 0);
        checkHead("t2.full", 0, 1, 0, 4);
        checkOutput("t2.overflow", 32'(overflow[0]), 1);
        overflow_clr[0] = 1'b1;
        applyStimulus(0, 0, 0, 0);
        overflow_clr[0] = 1'b0;
        checkOutput("t2.cleared", 32'(overflow[0]), 0);

        $display("[TB] NORMAL: push and pop together while full");
        applyStimulus(0, 1, 6, 1);
        checkHead("t3.pp", 0, 2, 0, 4);
        checkOutput("t3.overflow", 32'(overflow[0]), 0);
        overflow_clr[0] = 1'b1;
        applyStimulus(0, 1, 7, 0);
        checkOutput("t3.setwins", 32'(overflow[0]), 1);
        applyStimulus(0, 0, 0, 0);
        overflow_clr[0] = 1'b0;
        checkOutput("t3.clr", 32'(overflow[0]), 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t3.drain%0d", i), 32'(dout[0]), exp_d1[i]);
            applyStimulus(0, 0, 0, 1);
        end
        checkHead("t3.empty", 0, 0, 0, 0);

        $display("[TB] NORMAL: threshold load in the same cycle as a push");
        thresh_in[0] = 24'd100; thresh_load[0] = 1'b1;
        applyStimulus(0, 1, 80, 0);
        thresh_load[0] = 1'b0;
        applyStimulus(0, 1, 80, 0);
        applyStimulus(0, 0, 0, 0);
        checkHead("t6.a", 0, 80, 1, 2);
        applyStimulus(0, 0, 0, 1);
        checkHead("t6.b", 0, 80, 0, 1);
        applyStimulus(0, 0, 0, 1);

        $display("[TB] ACKNOWLEDGE: held valid captured once");
        applyStimulus(1, 1, 50, 0);
        checkHead("t4.cap", 1, 50, 1, 1);
        checkOutput("t4.ack1", 32'(count_ack[1]), 1);
        applyStimulus(1, 1, 50, 0);
        checkOutput("t4.ack2", 32'(count_ack[1]), 0);
        applyStimulus(1, 1, 50, 0);
        checkOutput("t4.ack3", 32'(count_ack[1]), 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkHead("t4.once", 1, 50, 1, 1);
        applyStimulus(1, 0, 0, 1);
        checkHead("t4.empty", 1, 0, 0, 0);

        $display("[TB] ACKNOWLEDGE: backpressure when full");
        for (int v = 30; v <= 33; v++) begin
            applyStimulus(1, 1, 24'(v), 0);
            applyStimulus(1, 0, 0, 0);
            applyStimulus(1, 0, 0, 0);
        end
        checkHead("t5.full", 1, 30, 0, 4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 99, 0);
            checkOutput("t5.noack", 32'(count_ack[1]), 0);
            checkOutput("t5.noovf", 32'(overflow[1]), 0);
        end
        applyStimulus(1, 1, 99, 1);
        checkHead("t5.cap", 1, 31, 0, 4);
        checkOutput("t5.ack", 32'(count_ack[1]), 1);
        applyStimulus(1, 1, 99, 0);
        checkOutput("t5.ackend", 32'(count_ack[1]), 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t5.drain%0d", i), 32'(dout[1]), exp_d2[i]);
            checkOutput($sformatf("t5.over%0d", i), 32'(dout_over[1]), exp_o2[i]);
            applyStimulus(1, 0, 0, 1);
        end

        $display("[TB] ACKNOWLEDGE: reset during ack recaptures held valid");
        applyStimulus(1, 1, 7, 0);
        checkOutput("rst.ack", 32'(count_ack[1]), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst.ack0", 32'(count_ack[1]), 0);
        checkOutput("rst.level0", 32'(level[1]), 0);
        cycle();
        rst_n = 1'b1;
        cycle();
        checkHead("rst.recap", 1, 7, 0, 1);
        checkOutput("rst.reack", 32'(count_ack[1]), 1);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
